ps2_key_multi: RTL

- Parametrised PS/2 keyboard receiver and direction decoder for up to 4 players.
- Sits between the PS/2 pins and the game logic.
- Receives full 11-bit frames with start, parity and stop checking, plus a watchdog that resynchronises after a lost bit.
- Decodes E0 (extended) and F0 (break) prefixes, tracks held keys per player, and outputs one-hot directions and a raw key-event strobe.

---
 rtl/ps2_key_multi.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_multi.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding and per-player held-key
// direction tracking for up to four players.
`timescale 1ns/1ps
module ps2_key_multi #(
  parameter int NUM_PLAYERS    = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int HOLD_MODE      = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_key_clk,
  input  logic                     i_key_data,
  output logic [4*NUM_PLAYERS-1:0] o_dir,
  output logic                     o_evt_valid,
  output logic [7:0]               o_evt_code,
  output logic                     o_evt_ext,
  output logic                     o_evt_break,
  output logic                     o_frame_err,
  output logic [7:0]               o_err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] kclk_sync_q, kdat_sync_q;
  logic kclk_prev_q;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic evt_valid_q, evt_valid_d, evt_ext_q, evt_ext_d, evt_brk_q, evt_brk_d;
  logic [7:0] evt_code_q, evt_code_d;
  logic err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [NUM_PLAYERS-1:0][3:0] held_q, held_d, act_q, act_d;

  logic fe, din, timeout, frame_done, frame_ok, bad, is_event;
  logic [4:0] km;
  logic [3:0] dbit;

  // Returns {hit, player, dir} with dir 3=up 2=down 1=left 0=right.
  function automatic logic [4:0] keymap(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h01D: return {1'b1, 2'd0, 2'd3};
      9'h01B: return {1'b1, 2'd0, 2'd2};
      9'h01C: return {1'b1, 2'd0, 2'd1};
      9'h023: return {1'b1, 2'd0, 2'd0};
      9'h043: return {1'b1, 2'd1, 2'd3};
      9'h042: return {1'b1, 2'd1, 2'd2};
      9'h03B: return {1'b1, 2'd1, 2'd1};
      9'h04B: return {1'b1, 2'd1, 2'd0};
      9'h175: return {1'b1, 2'd2, 2'd3};
      9'h172: return {1'b1, 2'd2, 2'd2};
      9'h16B: return {1'b1, 2'd2, 2'd1};
      9'h174: return {1'b1, 2'd2, 2'd0};
      9'h075: return {1'b1, 2'd3, 2'd3};
      9'h073: return {1'b1, 2'd3, 2'd2};
      9'h06B: return {1'b1, 2'd3, 2'd1};
      9'h074: return {1'b1, 2'd3, 2'd0};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] prio(input logic [3:0] held);
    casez (held)
      4'b1???: return 4'b1000;
      4'b01??: return 4'b0100;
      4'b001?: return 4'b0010;
      4'b0001: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  assign fe  = kclk_prev_q & ~kclk_sync_q[SYNC_STAGES-1];
  assign din = kdat_sync_q[SYNC_STAGES-1];
  assign timeout = (state_q != IDLE) && !fe && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fe && !din) state_d = DATA;
      DATA:   if (fe && bit_idx_q == 3'd7) state_d = PARITY;
      PARITY: if (fe) state_d = STOP;
      STOP:   if (fe) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  always_comb begin
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = (state_d == IDLE || fe) ? '0 : tmo_q + 1'b1;
    ext_d       = ext_q;
    brk_d       = brk_q;
    evt_valid_d = 1'b0;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_brk_d   = evt_brk_q;
    held_d      = held_q;
    act_d       = act_q;
    frame_done  = fe && (state_q == STOP);
    frame_ok    = din && (^{shift_q, parity_q});
    bad         = (frame_done && !frame_ok) || timeout;
    is_event    = frame_done && frame_ok && shift_q != 8'hE0 && shift_q != 8'hF0
                  && shift_q != 8'hE1;
    km          = keymap(ext_q, shift_q);
    dbit        = 4'b0001 << km[1:0];
    err_d       = bad;
    err_cnt_d   = (bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    if (fe && state_q == IDLE) bit_idx_d = 3'd0;
    if (fe && state_q == DATA) begin
      shift_d   = {din, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end
    if (fe && state_q == PARITY) parity_d = din;

    if (bad) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frame_done && frame_ok) begin
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end

    if (is_event) begin
      evt_valid_d = 1'b1;
      evt_code_d  = shift_q;
      evt_ext_d   = ext_q;
      evt_brk_d   = brk_q;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (km[4] && km[3:2] == 2'(p)) begin
          if (!brk_q) begin
            // A make of an already-held key is typematic repeat and is ignored.
            if ((held_q[p] & dbit) == 4'b0000) begin
              held_d[p] = held_q[p] | dbit;
              act_d[p]  = dbit;
            end
          end else begin
            held_d[p] = held_q[p] & ~dbit;
            if (HOLD_MODE != 0 && act_q[p] == dbit) act_d[p] = prio(held_q[p] & ~dbit);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
      kclk_prev_q <= 1'b1;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      held_q      <= '0;
      act_q       <= '0;
    end else begin
      kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], i_key_clk};
      kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], i_key_data};
      kclk_prev_q <= kclk_sync_q[SYNC_STAGES-1];
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_brk_q   <= evt_brk_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      held_q      <= held_d;
      act_q       <= act_d;
    end
  end

  assign o_dir       = act_q;
  assign o_evt_valid = evt_valid_q;
  assign o_evt_code  = evt_code_q;
  assign o_evt_ext   = evt_ext_q;
  assign o_evt_break = evt_brk_q;
  assign o_frame_err = err_q;
  assign o_err_cnt   = err_cnt_q;
endmodule
